// File: rtl/gpu_text_cmd.sv
// gpu_text_cmd: two-word CPU command processor driving a COLS x ROWS text buffer with cursor.
// Define GPU_SCROLL_EN to build hardware scrolling at end of screen (otherwise the cursor wraps).
module gpu_text_cmd #(
    parameter int COLS   = 40,
    parameter int ROWS   = 25,
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpuline,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic [ADDR_W-1:0] cur_x,
    output logic [ADDR_W-1:0] cur_y,
    output logic              busy
);
    localparam logic [1:0] OPC   = 2'd0;
    localparam logic [1:0] PARM  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] XMAX   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] YMAX   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(COLS * ROWS - 1);
`ifdef GPU_SCROLL_EN
    localparam logic [1:0] SCROLL = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(COLS * ROWS);
    logic [CHAR_W-1:0] rbuf;
    logic              put_eos;
`endif
    logic [1:0]        state;
    logic [15:0]       opcode;
    logic [ADDR_W-1:0] ptr, cnt, nl_y, nl_ptr, set_x, set_y, wa;
    logic [CHAR_W-1:0] mem [2**ADDR_W];
    logic [CHAR_W-1:0] wd;
    logic              accept, row_eos, we;

    // CLEAR and SCROLL share the high state bit, so it doubles as the busy flag
    assign busy      = state[1];
    assign cpu_ready = !state[1];
    assign accept    = cpu_valid && cpu_ready;

    always_comb begin
        row_eos = cur_y == YMAX;
`ifdef GPU_SCROLL_EN
        put_eos = row_eos && cur_x == XMAX;
        nl_y    = row_eos ? YMAX : cur_y + ONE;
        nl_ptr  = row_eos ? LAST_ROW : ptr - cur_x + COLS_A;
`else
        nl_y    = row_eos ? '0 : cur_y + ONE;
        nl_ptr  = row_eos ? '0 : ptr - cur_x + COLS_A;
`endif
        set_x   = cpuline > 16'(COLS - 1) ? XMAX : ADDR_W'(cpuline);
        set_y   = cpuline > 16'(ROWS - 1) ? YMAX : ADDR_W'(cpuline);
        we      = 1'b0;
        wa      = ptr;
        wd      = '0;
        if (state == PARM && accept && opcode == 16'h00C1) begin
            we = 1'b1;
            wd = cpuline[CHAR_W-1:0];
        end
        if (state == PARM && accept && opcode == 16'h00C2 && |ptr) begin
            we = 1'b1;
            wa = ptr - ONE;
        end
        if (state == CLEAR) begin
            we = 1'b1;
            wa = cnt;
        end
`ifdef GPU_SCROLL_EN
        // the copy write trails its read by one cycle; beyond the copy range it zero-fills
        if (state == SCROLL) begin
            we = cnt != '0;
            wa = cnt - ONE;
            wd = cnt <= LAST_ROW ? rbuf : '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (we && !reset) mem[wa] <= wd;
        rd_data <= reset ? '0 : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= OPC;
            opcode <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                OPC: if (accept && |cpuline) begin
                    opcode <= cpuline;
                    state  <= PARM;
                end
                PARM: if (accept) begin
                    state <= OPC;
                    case (opcode)
                        16'h00C0: begin
                            cur_x <= '0;
                            cur_y <= '0;
                            ptr   <= '0;
                        end
                        16'h00C1: begin
                            cur_x <= cur_x < XMAX ? cur_x + ONE : '0;
                            cur_y <= cur_x < XMAX ? cur_y : nl_y;
                            ptr   <= cur_x < XMAX ? ptr + ONE : nl_ptr;
`ifdef GPU_SCROLL_EN
                            if (put_eos) begin
                                state <= SCROLL;
                                cnt   <= '0;
                            end
`endif
                        end
                        16'h00C2: if (|ptr) begin
                            cur_x <= |cur_x ? cur_x - ONE : XMAX;
                            cur_y <= |cur_x ? cur_y : cur_y - ONE;
                            ptr   <= ptr - ONE;
                        end
                        16'h00C3: begin
                            cur_y <= set_y;
                            ptr   <= set_y * COLS_A + cur_x;
                        end
                        16'h00C4: begin
                            cur_x <= set_x;
                            ptr   <= cur_y * COLS_A + set_x;
                        end
                        16'h00C5: begin
                            cur_x <= '0;
                            cur_y <= '0;
                            ptr   <= '0;
                            cnt   <= '0;
                            state <= CLEAR;
                        end
                        16'h00C6: begin
                            cur_x <= '0;
                            cur_y <= nl_y;
                            ptr   <= nl_ptr;
`ifdef GPU_SCROLL_EN
                            if (row_eos) begin
                                state <= SCROLL;
                                cnt   <= '0;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
                CLEAR: begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST) state <= OPC;
                end
`ifdef GPU_SCROLL_EN
                SCROLL: begin
                    cnt  <= cnt + ONE;
                    rbuf <= mem[cnt + COLS_A];
                    if (cnt == SCROLL_END) state <= OPC;
                end
`endif
                default: state <= OPC;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_text_cmd.sv
// tb_gpu_text_cmd: randomized self-checking bench for gpu_text_cmd against a coordinate-level screen model.
module tb_gpu_text_cmd;
    localparam int COLS = 40;
    localparam int ROWS = 25;
    localparam int CELLS = COLS * ROWS;
`ifdef GPU_SCROLL_EN
    localparam int SCROLL_BUSY = CELLS + 1;
`else
    localparam int SCROLL_BUSY = 0;
`endif
    logic clk = 0, reset = 1, cpu_valid = 0, cpu_ready, busy;
    logic [15:0] cpuline = 0;
    logic [11:0] rd_addr = 0, cur_x, cur_y;
    logic [7:0] rd_data;
    logic [7:0] mb [CELLS];
    int passed = 0, total = 0;
    int mx = 0, my = 0, exp_busy = 0, meas_busy = 0;

    gpu_text_cmd dut (.clk(clk), .reset(reset), .cpuline(cpuline), .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready), .rd_addr(rd_addr), .rd_data(rd_data), .cur_x(cur_x),
        .cur_y(cur_y), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    task automatic m_row();
        my++;
        if (my == ROWS) begin
`ifdef GPU_SCROLL_EN
            my = ROWS - 1;
            for (int i = 0; i < CELLS - COLS; i++) mb[i] = mb[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++) mb[i] = 0;
            exp_busy = SCROLL_BUSY;
`else
            my = 0;
`endif
        end
    endtask

    task automatic m_exec(input logic [15:0] op, input logic [15:0] p);
        exp_busy = 0;
        case (op)
            16'h00C0: begin mx = 0; my = 0; end
            16'h00C1: begin
                mb[my * COLS + mx] = p[7:0];
                mx++;
                if (mx == COLS) begin mx = 0; m_row(); end
            end
            16'h00C2: if (mx != 0 || my != 0) begin
                if (mx > 0) mx--; else begin mx = COLS - 1; my--; end
                mb[my * COLS + mx] = 0;
            end
            16'h00C3: my = p > ROWS - 1 ? ROWS - 1 : int'(p);
            16'h00C4: mx = p > COLS - 1 ? COLS - 1 : int'(p);
            16'h00C5: begin
                for (int i = 0; i < CELLS; i++) mb[i] = 0;
                mx = 0; my = 0; exp_busy = CELLS;
            end
            16'h00C6: begin mx = 0; m_row(); end
            default: ;
        endcase
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        cpuline = w;
        cpu_valid = 1;
        while (!cpu_ready && n < 3000) begin @(negedge clk); n++; end
        total++;
        if (cpu_ready !== 1'b1) $display("FAIL send_timeout: ready=%b required 1 for word %h", cpu_ready, w);
        else passed++;
        @(negedge clk);
        cpu_valid = 0;
    endtask

    task automatic cmd(input logic [15:0] op, input logic [15:0] p);
        int n = 0;
        send(op);
        send(p);
        while (busy && n < 3000) begin @(negedge clk); n++; end
        meas_busy = n;
        m_exec(op, p);
    endtask

    task automatic read_cell(input int a, output logic [7:0] d);
        rd_addr = 12'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        total++; if (cpu_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", cpu_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
        total++; if (cur_x !== 12'd0) $display("FAIL reset_cur_x: got %0d required 0", cur_x); else passed++;
        total++; if (cur_y !== 12'd0) $display("FAIL reset_cur_y: got %0d required 0", cur_y); else passed++;
        total++; if (rd_data !== 8'd0) $display("FAIL reset_rd_data: got %h required 0", rd_data); else passed++;
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_put();
        logic [7:0] d;
        cmd(16'h00C1, 16'h0041);
        total++; if (cur_x !== 12'd1 || cur_y !== 12'd0) $display("FAIL put_cursor: got (%0d,%0d) required (1,0)", cur_x, cur_y); else passed++;
        read_cell(0, d);
        total++; if (d !== 8'h41) $display("FAIL put_cell0: got %h required 41", d); else passed++;
    endtask

    task automatic test_clear();
        int n = 0, bad = 0;
        logic [7:0] d;
        send(16'h00C5);
        send(16'h0000);
        m_exec(16'h00C5, 16'h0000);
        cpuline = 16'h00C4;
        cpu_valid = 1;
        total++; if (busy !== 1'b1) $display("FAIL clear_busy_start: got %b required 1", busy); else passed++;
        while (!cpu_ready && n < 3000) begin @(negedge clk); n++; end
        total++; if (n != CELLS) $display("FAIL clear_ready_low: got %0d cycles required %0d", n, CELLS); else passed++;
        @(negedge clk);
        send(16'd5);
        m_exec(16'h00C4, 16'd5);
        total++; if (cur_x !== 12'd5) $display("FAIL clear_held_word: cur_x=%0d required 5", cur_x); else passed++;
        for (int i = 0; i < CELLS; i++) begin read_cell(i, d); if (d !== 8'd0) bad++; end
        total++; if (bad != 0) $display("FAIL clear_cells: %0d nonzero cells required 0", bad); else passed++;
    endtask

    task automatic test_setxy_back();
        logic [7:0] d;
        cmd(16'h00C4, 16'h0027);
        cmd(16'h00C3, 16'h0005);
        cmd(16'h00C1, 16'h0042);
        total++; if (cur_x !== 12'd0 || cur_y !== 12'd6) $display("FAIL setxy_put_cursor: got (%0d,%0d) required (0,6)", cur_x, cur_y); else passed++;
        read_cell(239, d);
        total++; if (d !== 8'h42) $display("FAIL setxy_cell239: got %h required 42", d); else passed++;
        cmd(16'h00C4, 16'h00FF);
        total++; if (cur_x !== 12'd39) $display("FAIL setx_clamp: got %0d required 39", cur_x); else passed++;
        cmd(16'h00C3, 16'hFFFF);
        total++; if (cur_y !== 12'd24) $display("FAIL sety_clamp: got %0d required 24", cur_y); else passed++;
        cmd(16'h00C4, 16'h1005);
        total++; if (cur_x !== 12'd39) $display("FAIL setx_high_bits: got %0d required 39", cur_x); else passed++;
        cmd(16'h00C3, 16'h0006);
        cmd(16'h00C4, 16'h0000);
        cmd(16'h00C2, 16'h0000);
        total++; if (cur_x !== 12'd39 || cur_y !== 12'd5) $display("FAIL back_wrap: got (%0d,%0d) required (39,5)", cur_x, cur_y); else passed++;
        read_cell(239, d);
        total++; if (d !== 8'h00) $display("FAIL back_cell239: got %h required 00", d); else passed++;
        cmd(16'h00C0, 16'h0000);
        cmd(16'h00C2, 16'h0000);
        total++; if (cur_x !== 12'd0 || cur_y !== 12'd0) $display("FAIL back_origin: got (%0d,%0d) required (0,0)", cur_x, cur_y); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] op, p;
        logic [7:0] d;
        int bad = 0;
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0: op = 16'h0000;
                1: op = 16'h0100 | 16'($urandom_range(0, 255));
                2: op = 16'h00C0;
                5: op = 16'h00C2;
                6: op = 16'h00C3;
                7: op = 16'h00C4;
                8: op = 16'h00C6;
                default: op = 16'h00C1;
            endcase
            p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 50));
            if (op == 16'h0000) send(op);
            else cmd(op, p);
            total++; if (cur_x !== 12'(mx) || cur_y !== 12'(my)) $display("FAIL rand_cursor: op %h got (%0d,%0d) required (%0d,%0d)", op, cur_x, cur_y, mx, my); else passed++;
            if (op != 16'h0000) begin
                total++; if (meas_busy != exp_busy) $display("FAIL rand_busy: op %h got %0d cycles required %0d", op, meas_busy, exp_busy); else passed++;
            end
        end
        for (int i = 0; i < CELLS; i++) begin read_cell(i, d); if (d !== mb[i]) bad++; end
        total++; if (bad != 0) $display("FAIL rand_buffer: %0d cells differ required 0", bad); else passed++;
    endtask

    task automatic test_fill_scroll();
        logic [7:0] d;
        int bad = 0;
        cmd(16'h00C5, 16'h0000);
        total++; if (meas_busy != CELLS) $display("FAIL fill_clear_busy: got %0d required %0d", meas_busy, CELLS); else passed++;
        for (int i = 0; i < CELLS; i++) cmd(16'h00C1, 16'(8'h41 + i / COLS));
        total++; if (meas_busy != SCROLL_BUSY) $display("FAIL eos_busy: got %0d required %0d", meas_busy, SCROLL_BUSY); else passed++;
        cmd(16'h00C1, 16'h005A);
`ifdef GPU_SCROLL_EN
        total++; if (cur_x !== 12'd1 || cur_y !== 12'd24) $display("FAIL scroll_cursor: got (%0d,%0d) required (1,24)", cur_x, cur_y); else passed++;
        read_cell(0, d);
        total++; if (d !== 8'h42) $display("FAIL scroll_row0: got %h required 42", d); else passed++;
        read_cell(960, d);
        total++; if (d !== 8'h5A) $display("FAIL scroll_cell960: got %h required 5a", d); else passed++;
        read_cell(961, d);
        total++; if (d !== 8'h00) $display("FAIL scroll_cell961: got %h required 00", d); else passed++;
`else
        total++; if (cur_x !== 12'd1 || cur_y !== 12'd0) $display("FAIL wrap_cursor: got (%0d,%0d) required (1,0)", cur_x, cur_y); else passed++;
        read_cell(0, d);
        total++; if (d !== 8'h5A) $display("FAIL wrap_cell0: got %h required 5a", d); else passed++;
        read_cell(999, d);
        total++; if (d !== 8'h59) $display("FAIL wrap_cell999: got %h required 59", d); else passed++;
`endif
        for (int i = 0; i < CELLS; i++) begin read_cell(i, d); if (d !== mb[i]) bad++; end
        total++; if (bad != 0) $display("FAIL fill_buffer: %0d cells differ required 0", bad); else passed++;
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] d;
        int bad = 0;
        send(16'h00C5);
        send(16'h0000);
        repeat (500) @(negedge clk);
        reset = 1;
        @(negedge clk);
        total++; if (cpu_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort_flags: ready=%b busy=%b required 1/0", cpu_ready, busy); else passed++;
        total++; if (cur_x !== 12'd0 || cur_y !== 12'd0) $display("FAIL abort_cursor: got (%0d,%0d) required (0,0)", cur_x, cur_y); else passed++;
        reset = 0;
        for (int i = 0; i < 500; i++) mb[i] = 0;
        mx = 0; my = 0;
        for (int i = 0; i < CELLS; i++) begin read_cell(i, d); if (d !== mb[i]) bad++; end
        total++; if (bad != 0) $display("FAIL abort_buffer: %0d cells differ required 0", bad); else passed++;
    endtask

    task automatic test_rd_latency();
        rd_addr = 0;
        send(16'h00C1);
        send(16'h0033);
        total++; if (rd_data !== mb[0]) $display("FAIL rd_old_data: got %h required %h", rd_data, mb[0]); else passed++;
        m_exec(16'h00C1, 16'h0033);
        @(negedge clk);
        total++; if (rd_data !== 8'h33) $display("FAIL rd_new_data: got %h required 33", rd_data); else passed++;
    endtask

    initial begin
        for (int i = 0; i < CELLS; i++) mb[i] = 0;
        @(negedge clk);
        test_reset();
        test_put();
        test_clear();
        test_setxy_back();
        test_random();
        test_fill_scroll();
        test_reset_mid_clear();
        test_rd_latency();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
